// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute stage. Most ops complete in one cycle.
// DIV runs a restoring divider for WIDTH cycles. The result is held until
// writeback accepts it.
module alu_exec_unit #(
  parameter int WIDTH         = 8,
  parameter int INVALID_VALUE = 77
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_dbz,
  output logic             flag_illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic { IDLE, DIV_BUSY } state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
    OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6
  } op_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   dvd, dvs, rem;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum, diff, rem_shift, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem_next, dvd_next;
  logic               q_bit;

  logic [WIDTH-1:0]   sc_result, sc_hi;
  logic               sc_carry, sc_dbz, sc_illegal;
  logic               in_xfer, out_xfer, div_start, div_done, sc_load;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign div_start = in_xfer && (op == OP_DIV) && (src2 != '0);
  assign sc_load   = in_xfer && !div_start;
  assign div_done  = (state == DIV_BUSY) && (cnt == CW'(1));

  assign sum  = {1'b0, src1} + {1'b0, src2};
  assign diff = {1'b0, src1} - {1'b0, src2};
  assign prod = {{WIDTH{1'b0}}, src1} * {{WIDTH{1'b0}}, src2};

  // One restoring step: shift remainder:dividend left, trial-subtract divisor.
  always_comb begin
    rem_shift = {rem, dvd[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs};
    q_bit     = !trial[WIDTH];
    rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    dvd_next  = {dvd[WIDTH-2:0], q_bit};
  end

  // Single-cycle result selection; the DIV arm only applies to divide-by-zero.
  always_comb begin
    sc_result  = '0;
    sc_hi      = '0;
    sc_carry   = 1'b0;
    sc_dbz     = 1'b0;
    sc_illegal = 1'b0;
    case (op_t'(op))
      OP_ADD: begin sc_result = sum[WIDTH-1:0];  sc_carry = sum[WIDTH];  end
      OP_SUB: begin sc_result = diff[WIDTH-1:0]; sc_carry = diff[WIDTH]; end
      OP_MUL: begin
        sc_result = prod[WIDTH-1:0];
        sc_hi     = prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin sc_result = '1; sc_hi = src1; sc_dbz = 1'b1; end
      OP_AND: sc_result = src1 & src2;
      OP_OR:  sc_result = src1 | src2;
      OP_XOR: sc_result = src1 ^ src2;
      default: begin
        sc_result  = WIDTH'(INVALID_VALUE);
        sc_illegal = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (div_start) state_next = DIV_BUSY;
      DIV_BUSY: if (div_done)  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Divider working registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (div_start) begin
      dvd <= src1;
      dvs <= src2;
      rem <= '0;
      cnt <= CW'(WIDTH);
    end else if (state == DIV_BUSY) begin
      dvd <= dvd_next;
      rem <= rem_next;
      cnt <= cnt - CW'(1);
    end
  end

  // Output stage: a new load wins over a drain at the same edge, so
  // back-to-back single-cycle ops keep out_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      result       <= '0;
      result_hi    <= '0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
      flag_dbz     <= 1'b0;
      flag_illegal <= 1'b0;
    end else if (sc_load) begin
      out_valid    <= 1'b1;
      result       <= sc_result;
      result_hi    <= sc_hi;
      flag_zero    <= (sc_result == '0);
      flag_carry   <= sc_carry;
      flag_dbz     <= sc_dbz;
      flag_illegal <= sc_illegal;
    end else if (div_done) begin
      out_valid    <= 1'b1;
      result       <= dvd_next;
      result_hi    <= rem_next;
      flag_zero    <= (dvd_next == '0);
      flag_carry   <= 1'b0;
      flag_dbz     <= 1'b0;
      flag_illegal <= 1'b0;
    end else if (out_xfer) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (WIDTH = 8, INVALID_VALUE = 77).
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_exec_unit;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready;
  logic [3:0] op;
  logic [7:0] src1, src2;
  logic       in_ready, out_valid;
  logic [7:0] result, result_hi;
  logic       flag_zero, flag_carry, flag_dbz, flag_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  alu_exec_unit #(.WIDTH(8), .INVALID_VALUE(77)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_dbz(flag_dbz), .flag_illegal(flag_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
  endtask

  task automatic check_out(input string tag, input logic [7:0] r, input logic [7:0] hi,
                           input logic z, input logic c, input logic d, input logic il);
    check({tag, ".valid"},   32'(out_valid),    32'd1);
    check({tag, ".result"},  32'(result),       32'(r));
    check({tag, ".hi"},      32'(result_hi),    32'(hi));
    check({tag, ".zero"},    32'(flag_zero),    32'(z));
    check({tag, ".carry"},   32'(flag_carry),   32'(c));
    check({tag, ".dbz"},     32'(flag_dbz),     32'(d));
    check({tag, ".illegal"}, 32'(flag_illegal), 32'(il));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"},   32'(out_valid), 32'd0);
    check({tag, ".ready"},   32'(in_ready),  32'd1);
    check({tag, ".result"},  32'(result),    32'd0);
    check({tag, ".hi"},      32'(result_hi), 32'd0);
    check({tag, ".flags"},
          32'({flag_zero, flag_carry, flag_dbz, flag_illegal}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_lo, stray;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");

    // Back-to-back single-cycle ops.
    drive(4'd0, 8'd200, 8'd100);
    check("add.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_out("add", 8'd44, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'd1, 8'd5, 8'd7);
    @(negedge clk);
    check_out("sub", 8'd254, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'd6, 8'hF0, 8'hFF);
    @(negedge clk);
    check_out("xor", 8'h0F, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(4'd2, 8'd250, 8'd3);
    @(negedge clk);
    check_out("mul", 8'hEE, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'd2, 8'd0, 8'd9);
    @(negedge clk);
    check_out("mul0", 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Iterative divide: WIDTH busy cycles with in_ready low.
    drive(4'd3, 8'd200, 8'd7);
    check("div.accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; busy_lo = 0;
    while (!out_valid && lat < 20) begin
      if (!in_ready) busy_lo++;
      @(negedge clk);
      lat++;
    end
    check("div.latency", 32'(lat), 32'd8);
    check("div.busy_ready_low", 32'(busy_lo), 32'd8);
    check_out("div", 8'd28, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(4'd3, 8'd9, 8'd0);
    check("dbz.accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_out("dbz", 8'd255, 8'd9, 1'b0, 1'b0, 1'b1, 1'b0);

    drive(4'd9, 8'd3, 8'd4);
    @(negedge clk);
    check_out("illegal", 8'd77, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held, nothing accepted.
    drive(4'd0, 8'd1, 8'd1);
    @(negedge clk);
    check_out("bp.add", 8'd2, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'd0, 8'(i + 5), 8'd3);
      @(negedge clk);
      check("bp.hold_result", 32'(result), 32'd2);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.out_valid", 32'(out_valid), 32'd1);
    end
    drive(4'd0, 8'd10, 8'd20);
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_out("bp.next", 8'd30, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during a divide aborts it.
    drive(4'd3, 8'd100, 8'd3);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort.busy", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("abort");
    drive(4'd0, 8'd1, 8'd2);
    @(negedge clk);
    check_out("post_abort.add", 8'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("post_abort.no_result", 32'(stray), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, handshaked execute stage for the CPU datapath: takes an opcode and two operands from decode, computes one result (single-cycle for most ops, iterative for divide), and holds it for writeback until accepted. It succeeds the fixed 8-bit, always-ready execute stage by adding:

- configurable width;
- valid/ready flow control on both sides;
- a multi-cycle restoring divider;
- a high result word;
- status flags.

## Interface

Parameters:

- WIDTH, default 8: operand and result width, ≥ 2.
- INVALID_VALUE, default 77: result driven for an unsupported opcode, truncated to WIDTH.

Ports:

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  op/src1/src2 valid.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  4  opcode.
- src1  in  WIDTH  first operand (dividend for DIV).
- src2  in  WIDTH  second operand (divisor for DIV).
- out_valid  out  1  result/result_hi/flags valid.
- out_ready  in  1  writeback accepts the result.
- result  out  WIDTH  primary result.
- result_hi  out  WIDTH  MUL high half, DIV remainder, else 0.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  ADD carry-out, SUB borrow (src1 < src2), else 0.
- flag_dbz  out  1  DIV with src2 == 0.
- flag_illegal  out  1  unsupported opcode.

## Operation

Transfers:

- Input transfer: in_valid && in_ready at a rising edge.
- Output transfer: out_valid && out_ready at a rising edge.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Purely combinational from registered state and out_ready; never depends on in_valid.

Opcodes (all arithmetic unsigned, modulo 2^WIDTH):

- 0 ADD: result = low WIDTH bits of src1+src2; carry = bit WIDTH.
- 1 SUB: result = src1−src2 mod 2^WIDTH; carry = borrow.
- 2 MUL: full 2·WIDTH product; result = low half, result_hi = high half.
- 3 DIV: result = quotient, result_hi = remainder.
- 4 AND, 5 OR, 6 XOR: bitwise; result_hi = 0.
- 7–15: result = INVALID_VALUE, result_hi = 0, flag_illegal = 1.

Divide by zero:

- result = all ones, result_hi = src1, flag_dbz = 1.
- Completes with single-cycle latency; the divider is not entered.

flag_zero reflects result only, not result_hi.

State machine:

- IDLE: accepting.
  - Non-DIV op, or DIV with src2 == 0: output registers load at the transfer edge; out_valid = 1; stay IDLE.
  - DIV with src2 ≠ 0: latch dividend/divisor, clear remainder, counter = WIDTH; go to DIV_BUSY.
- DIV_BUSY: one restoring-division step per cycle (shift remainder:dividend left one, trial-subtract divisor, set quotient bit); counter decrements.
  - On the step where counter reaches 0: load outputs, out_valid = 1, go to IDLE.
  - in_ready = 0 throughout.

Output holding:

- The output registers and flags hold stable while out_valid && !out_ready.
- out_valid clears on an output transfer unless a new input transfer completes a single-cycle op at the same edge; in that case out_valid stays 1 with the new data.

Reset:

- Every output register is 0 and out_valid is 0; state is IDLE.
- Consequently in_ready = 1 in the first cycle after reset.
- Reset during DIV_BUSY aborts the division; no result is produced.

## Timing

- Single-cycle ops: input transfer at edge N → out_valid and data visible after edge N.
- DIV (src2 ≠ 0): input transfer at edge N → out_valid after edge N+WIDTH, i.e. WIDTH busy cycles.
- Throughput: one single-cycle op per clock while out_ready = 1. DIV: one per WIDTH+1 clocks at best.
- Backpressure: if out_valid && !out_ready, in_ready = 0.
  - No input is accepted.
  - No result is overwritten.
  - No result is dropped.
- A DIV finishing while an older result is still held cannot occur: entry to DIV requires an empty or draining output stage.
- Simultaneous output transfer and DIV acceptance at edge N: out_valid = 0 after N; the quotient appears after N+WIDTH.

## Test plan

All scenarios use WIDTH = 8, INVALID_VALUE = 77.

- Reset, then back-to-back ADD 200+100, SUB 5−7, XOR 0xF0^0xFF with out_ready = 1 → results 44 (carry 1), 254 (carry 1), 0x0F on three consecutive cycles, each one cycle after its transfer.
- MUL 250×3 → result 0xEE, result_hi 0x02, zero 0. MUL 0×9 → result 0, flag_zero 1.
- DIV 200/7 → in_ready low for 8 cycles; result 28, result_hi 4 exactly 8 edges after acceptance. DIV 9/0 → result 255, result_hi 9, flag_dbz 1, latency 1.
- op = 9, src1 = 3, src2 = 4 → result 77, flag_illegal 1, result_hi 0.
- Hold out_ready low for 5 cycles after ADD 1+1 with in_valid held high and changing operands → result stays 2, in_ready stays 0. Then raise out_ready: the next op is accepted at the same edge the result is taken.
- Assert reset on the 3rd busy cycle of DIV 100/3 → out_valid 0, all outputs 0, in_ready 1 next cycle. A following ADD 1+2 → result 3.
